// File: rtl/pc_unit_pkg.sv
// Shared encodings, default vectors and the interrupt-id width helper for pc_unit.
package pc_unit_pkg;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

  // Width of an interrupt index, never narrower than one bit.
  function automatic int unsigned irq_id_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_unit_irq_pending.sv
// Edge-latched, maskable interrupt pending bits with lowest-index-wins priority.
// PC_UNIT_IRQ_SYNC_EN adds a 2-flop synchronizer ahead of edge detection.
module irq_pending
  import pc_unit_pkg::*;
#(
  parameter int unsigned IRQ_N = 4,
  parameter int unsigned ID_W  = irq_id_w(IRQ_N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_N-1:0] irq,
  input  logic [IRQ_N-1:0] mask,
  input  logic             clr,
  input  logic [ID_W-1:0]  clr_id,
  output logic             any,
  output logic [ID_W-1:0]  id
);

  logic [IRQ_N-1:0] seen;
  logic [IRQ_N-1:0] prev_q;
  logic [IRQ_N-1:0] pending_q, pending_d;
  logic [IRQ_N-1:0] rise, clr_vec, eligible;

`ifdef PC_UNIT_IRQ_SYNC_EN
  logic [IRQ_N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign seen = sync2_q;
`else
  assign seen = irq;
`endif

  assign rise     = seen & ~prev_q;
  assign eligible = pending_q & mask;
  assign any      = |eligible;

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < IRQ_N; i++) begin
      clr_vec[i] = clr && (clr_id == ID_W'(i));
    end
    // A fresh edge on the line being cleared keeps it pending.
    pending_d = (pending_q & ~clr_vec) | rise;
  end

  always_comb begin
    id = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (eligible[i]) id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= seen;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter sequencer: PC, kernel bit, exception/interrupt vectoring and EPC.
// Define PC_UNIT_IRQ_SYNC_EN to synchronize asynchronous iIrq sources.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        IRQ_N     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [ADDR_W-1:0] EXC_VEC   = DEF_EXC_VEC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iStall,
  input  logic [1:0]                   iPCSrc,
  input  logic                         iBranchTaken,
  input  logic [ADDR_W-1:0]            iBranchOffset,
  input  logic [25:0]                  iJumpIndex,
  input  logic [ADDR_W-1:0]            iRegTarget,
  input  logic                         iOverflow,
  input  logic                         iEret,
  input  logic [IRQ_N-1:0]             iIrq,
  input  logic [IRQ_N-1:0]             iIrqMask,
  output logic [ADDR_W-1:0]            oPC,
  output logic [ADDR_W-1:0]            oPCPlus4,
  output logic [ADDR_W-1:0]            oEPC,
  output logic                         oKernel,
  output logic                         oSquash,
  output logic                         oIrqTaken,
  output logic                         oExcTaken,
  output logic [irq_id_w(IRQ_N)-1:0]   oIrqId
);

  localparam int unsigned ID_W = irq_id_w(IRQ_N);

  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [ADDR_W-1:0] pc_plus4, next_normal;
  logic              kernel, irq_any;
  logic              exc_take, eret_take, irq_take;
  logic [ID_W-1:0]   irq_id;

  irq_pending #(
    .IRQ_N (IRQ_N),
    .ID_W  (ID_W)
  ) u_irq_pending (
    .clk    (clk),
    .reset  (reset),
    .irq    (iIrq),
    .mask   (iIrqMask),
    .clr    (irq_take),
    .clr_id (irq_id),
    .any    (irq_any),
    .id     (irq_id)
  );

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign kernel   = pc_q[ADDR_W-1];

  assign exc_take  = ~iStall & iOverflow;
  assign eret_take = ~iStall & ~iOverflow & iEret;
  assign irq_take  = ~iStall & ~iOverflow & ~iEret & ~kernel & irq_any;

  always_comb begin
    next_normal = pc_plus4;
    case (iPCSrc)
      PCSRC_BRANCH: if (iBranchTaken) next_normal = pc_plus4 + (iBranchOffset << 2);
      PCSRC_JUMP:   next_normal = {pc_plus4[ADDR_W-1:28], iJumpIndex, 2'b00};
      PCSRC_REG:    next_normal = iRegTarget;
      default:      next_normal = pc_plus4;
    endcase
    // Only jr/jalr may cross between user and kernel space.
    if (iPCSrc != PCSRC_REG) next_normal[ADDR_W-1] = kernel;
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (iStall) begin
      pc_d = pc_q;
    end else if (exc_take) begin
      epc_d = pc_q;
      pc_d  = EXC_VEC;
    end else if (eret_take) begin
      pc_d = {1'b0, epc_q[ADDR_W-2:0]};
    end else if (irq_take) begin
      epc_d = pc_q;
      pc_d  = IRQ_VEC;
    end else begin
      pc_d = next_normal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign oPC       = pc_q;
  assign oPCPlus4  = pc_plus4;
  assign oEPC      = epc_q;
  assign oKernel   = kernel;
  assign oSquash   = exc_take | irq_take;
  assign oIrqTaken = irq_take;
  assign oExcTaken = exc_take;
  assign oIrqId    = irq_take ? irq_id : '0;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed test-plan steps then random traffic
// against a behavioural model. Honours PC_UNIT_IRQ_SYNC_EN for IRQ latency.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, btaken, ovf, eret;
  logic [1:0]  src;
  logic [31:0] boff, rtgt;
  logic [25:0] jidx;
  logic [3:0]  irq, mask;

  logic [31:0] o_pc, o_pc4, o_epc;
  logic        o_kernel, o_squash, o_irq_taken, o_exc_taken;
  logic [1:0]  o_irq_id;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [3:0]  m_pend, m_prev, m_s1, m_s2;
  logic        m_exc, m_eret, m_irq;
  int          m_win;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .iStall        (stall),
    .iPCSrc        (src),
    .iBranchTaken  (btaken),
    .iBranchOffset (boff),
    .iJumpIndex    (jidx),
    .iRegTarget    (rtgt),
    .iOverflow     (ovf),
    .iEret         (eret),
    .iIrq          (irq),
    .iIrqMask      (mask),
    .oPC           (o_pc),
    .oPCPlus4      (o_pc4),
    .oEPC          (o_epc),
    .oKernel       (o_kernel),
    .oSquash       (o_squash),
    .oIrqTaken     (o_irq_taken),
    .oExcTaken     (o_exc_taken),
    .oIrqId        (o_irq_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] irq_seen();
`ifdef PC_UNIT_IRQ_SYNC_EN
    return m_s2;
`else
    return irq;
`endif
  endfunction

  // Predict this cycle's events from the model and compare every output.
  task automatic eval();
    logic [3:0] elig;
    #1;
    elig  = m_pend & mask;
    m_win = -1;
    for (int i = 0; i < 4; i++) if (elig[i] && m_win < 0) m_win = i;
    m_exc  = !stall && ovf;
    m_eret = !stall && !ovf && eret;
    m_irq  = !stall && !ovf && !eret && !m_pc[31] && (m_win >= 0);
    check("pc", o_pc, m_pc);
    check("pc_plus4", o_pc4, m_pc + 32'd4);
    check("epc", o_epc, m_epc);
    check("kernel", 32'(o_kernel), 32'(m_pc[31]));
    check("squash", 32'(o_squash), 32'(m_exc || m_irq));
    check("irq_taken", 32'(o_irq_taken), 32'(m_irq));
    check("exc_taken", 32'(o_exc_taken), 32'(m_exc));
    if (m_irq) check("irq_id", 32'(o_irq_id), 32'(m_win));
  endtask

  // Clock the DUT once and move the model to its next state.
  task automatic advance();
    logic [31:0] pc4, nxt, npc, nepc;
    logic [3:0]  s, rise, clr;
    pc4 = m_pc + 32'd4;
    case (src)
      2'd0:    nxt = pc4;
      2'd1:    nxt = btaken ? pc4 + boff * 32'd4 : pc4;
      2'd2:    nxt = {pc4[31:28], jidx, 2'b00};
      default: nxt = rtgt;
    endcase
    if (src != 2'd3) nxt[31] = m_pc[31];
    s    = irq_seen();
    rise = s & ~m_prev;
    clr  = 4'b0;
    if (m_irq) clr[m_win] = 1'b1;
    npc  = m_pc;
    nepc = m_epc;
    if (stall) npc = m_pc;
    else if (m_exc) begin nepc = m_pc; npc = 32'h8000_0008; end
    else if (m_eret) npc = {1'b0, m_epc[30:0]};
    else if (m_irq) begin nepc = m_pc; npc = 32'h8000_0004; end
    else npc = nxt;
    @(posedge clk);
    m_pend = (m_pend & ~clr) | rise;
    m_prev = s;
    m_s2   = m_s1;
    m_s1   = irq;
    m_pc   = npc;
    m_epc  = nepc;
    @(negedge clk);
  endtask

  task automatic step();
    eval();
    advance();
  endtask

  // Sit at pc via jr until the model predicts an IRQ; bounded.
  task automatic wait_irq(input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      src  = 2'd3;
      rtgt = pc;
      eval();
      if (m_irq) begin
        ok = 1'b1;
        break;
      end
      advance();
    end
    check("irq_wait_bound", 32'(ok), 32'd1);
  endtask

  task automatic eret_back();
    src  = 2'd0;
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b1; src = 2'd0; btaken = 1'b0; boff = '0; jidx = '0;
    rtgt = '0; ovf = 1'b0; eret = 1'b0; irq = '0; mask = '0;
    m_pc = 32'h8000_0000; m_epc = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    @(negedge clk);
    eval();
    @(negedge clk);
    reset = 1'b1;  // released while stalled
    step();
    check("reset_pc", o_pc, 32'h8000_0000);
    check("reset_kernel", 32'(o_kernel), 32'd1);
    stall = 1'b0;

    src = 2'd3; rtgt = 32'h0000_0040; step();
    check("jr_pc", o_pc, 32'h0000_0040);
    check("jr_kernel", 32'(o_kernel), 32'd0);

    src = 2'd1; btaken = 1'b1; boff = 32'hffff_ffff; step();
    btaken = 1'b0; boff = '0;
    check("branch_back", o_pc, 32'h0000_0040);

    src = 2'd2; jidx = 26'h10; step();
    check("jump_pc", o_pc, 32'h0000_0040);
    check("jump_kernel", 32'(o_kernel), 32'd0);

    // IRQ priority: lines 1 and 2 pend, line 1 first.
    src = 2'd3; rtgt = 32'h0000_0100; irq = 4'b0110; mask = 4'b1111; step();
    irq = 4'b0;
    wait_irq(32'h0000_0100);
    check("prio_taken", 32'(o_irq_taken), 32'd1);
    check("prio_id", 32'(o_irq_id), 32'd1);
    check("prio_squash", 32'(o_squash), 32'd1);
    advance();
    check("irq_vec", o_pc, 32'h8000_0004);
    check("irq_epc", o_epc, 32'h0000_0100);
    eret_back();
    check("eret_pc", o_pc, 32'h0000_0100);
    wait_irq(32'h0000_0100);
    check("second_id", 32'(o_irq_id), 32'd2);
    advance();
    eret_back();

    // Overflow under stall is ignored, then taken.
    src = 2'd0; stall = 1'b1; ovf = 1'b1; eval();
    check("stall_no_exc", 32'(o_exc_taken), 32'd0);
    advance();
    check("stall_pc_hold", o_pc, 32'h0000_0100);
    stall = 1'b0; eval();
    check("exc_taken", 32'(o_exc_taken), 32'd1);
    advance();
    ovf = 1'b0;
    check("exc_vec", o_pc, 32'h8000_0008);
    check("exc_epc", o_epc, 32'h0000_0100);

    // Edge in kernel mode stays pending until ERET.
    irq = 4'b1000; step();
    irq = 4'b0;
    for (int k = 0; k < 4; k++) begin
      eval();
      check("kernel_no_irq", 32'(o_irq_taken), 32'd0);
      advance();
    end
    eret_back();
    src = 2'd3; rtgt = 32'h0000_0100; eval();
    check("after_eret_taken", 32'(o_irq_taken), 32'd1);
    check("after_eret_id", 32'(o_irq_id), 32'd3);
    advance();
    eret_back();

    // Masked line held until unmasked.
    mask = 4'b0; irq = 4'b0001; src = 2'd3; step();
    irq = 4'b0;
    for (int k = 0; k < 4; k++) begin
      eval();
      check("masked_no_irq", 32'(o_irq_taken), 32'd0);
      advance();
    end
    mask = 4'b0001; eval();
    check("unmask_taken", 32'(o_irq_taken), 32'd1);
    check("unmask_id", 32'(o_irq_id), 32'd0);
    advance();
    eret_back();

    // Overflow beats an eligible IRQ; the IRQ stays pending.
    mask = 4'b0; irq = 4'b0010; src = 2'd3; step();
    irq = 4'b0;
    repeat (3) step();
    mask = 4'b1111; ovf = 1'b1; eval();
    check("sim_exc", 32'(o_exc_taken), 32'd1);
    check("sim_no_irq", 32'(o_irq_taken), 32'd0);
    advance();
    ovf = 1'b0;
    eret_back();
    src = 2'd3; rtgt = o_pc; eval();
    check("retained_taken", 32'(o_irq_taken), 32'd1);
    check("retained_id", 32'(o_irq_id), 32'd1);
    advance();
    eret_back();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r      = 8'($urandom);
      stall  = ($urandom_range(0, 3) == 0);
      src    = 2'($urandom);
      btaken = 1'($urandom);
      boff   = {{24{r[7]}}, r};
      jidx   = 26'($urandom);
      rtgt   = $urandom & 32'hffff_fffc;
      ovf    = ($urandom_range(0, 9) == 0);
      eret   = ($urandom_range(0, 7) == 0);
      irq    = 4'($urandom);
      mask   = 4'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter sequencer for the MIPS cores. It replaces the ad-hoc next-PC mux with one block that owns four things: the PC register, the user/kernel bit, the exception/interrupt vectoring and the saved return address (EPC). Beyond the single-cycle PC logic, it adds N prioritised, maskable, edge-latched interrupt lines, a fetch-stall handshake, an explicit ERET path and a squash signal to the datapath.

## Interface
Parameters:
- ADDR_W, 32, address width; bit ADDR_W-1 is the kernel bit
- IRQ_N, 4, interrupt lines (1..16)
- RESET_VEC, 32'h8000_0000, PC after reset
- IRQ_VEC, 32'h8000_0004, interrupt entry
- EXC_VEC, 32'h8000_0008, overflow-exception entry

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- iStall  in  1  fetch not ready; hold PC, take no event
- iPCSrc  in  2  00 PC+4, 01 branch, 10 jump, 11 register (jr/jalr)
- iBranchTaken  in  1  branch condition true
- iBranchOffset  in  ADDR_W  sign-extended word offset
- iJumpIndex  in  26  J-type index field
- iRegTarget  in  ADDR_W  register jump target
- iOverflow  in  1  ALU overflow on current instruction
- iEret  in  1  return from exception
- iIrq  in  IRQ_N  level interrupt requests
- iIrqMask  in  IRQ_N  1 = line enabled
- oPC  out  ADDR_W  current PC
- oPCPlus4  out  ADDR_W  PC+4
- oEPC  out  ADDR_W  saved return address
- oKernel  out  1  oPC[ADDR_W-1]
- oSquash  out  1  suppress current instruction's register and memory writes
- oIrqTaken  out  1  interrupt vectored this cycle
- oExcTaken  out  1  exception vectored this cycle
- oIrqId  out  clog2(IRQ_N) (min 1)  index of the taken line

## Operation
- Reset values: PC=RESET_VEC, EPC=0, all pending bits=0, sync and edge flops=0. oSquash, oIrqTaken and oExcTaken are 0.
- Normal next-PC targets:
  - PC+4.
  - Branch: PC+4+(offset<<2) if iBranchTaken, else PC+4.
  - Jump: {PC+4[ADDR_W-1:28], index, 2'b00}.
  - Register: iRegTarget.
  - All arithmetic is modulo 2^ADDR_W.
- Kernel-bit preservation: on the PC+4, branch and jump paths, bit ADDR_W-1 of the next PC is forced to the current kernel bit. Only the register path, the vector paths and ERET may change it.
- Interrupt lines:
  - A rising edge on iIrq[i] sets pending[i].
  - Only pending & mask lines are eligible.
  - The lowest eligible index wins.
  - A masked pending bit stays set until it is unmasked and taken.
- Priority, evaluated only when iStall=0:
  1. Overflow: oExcTaken=1, oSquash=1, EPC<=PC, PC<=EXC_VEC. Allowed in either mode.
  2. ERET: PC<=EPC with the kernel bit cleared.
  3. IRQ, only when oKernel=0 and a line is eligible: oIrqTaken=1, oSquash=1, oIrqId=winner, EPC<=PC, pending[winner]<=0, PC<=IRQ_VEC.
  4. Normal next-PC.
- In kernel mode, interrupts are not taken; they stay pending.
- When iStall=1:
  - PC, EPC, oSquash, oIrqTaken and oExcTaken hold at 0 or unchanged as appropriate; iOverflow and iEret are ignored.
  - Edge capture into pending continues.
- If a new edge arrives on the winner line in the same cycle it is taken, pending stays set (set wins over clear).

## Timing
- All outputs are registered state or combinational decode of state plus same-cycle inputs; no multi-cycle handshakes.
- oSquash, oIrqTaken, oExcTaken and oIrqId are valid in the cycle the event is taken. The vector appears on oPC after the next edge.
- IRQ latency, iIrq high before sampling edge E0, user mode, no stall:
  - Without sync: pending set at E0, taken in the cycle after E0, PC=IRQ_VEC after E1.
  - With sync: two edges more, PC=IRQ_VEC after E3.
- Reset deasserting mid-stall: PC=RESET_VEC; first fetch is at RESET_VEC.

## Configuration
- PC_UNIT_IRQ_SYNC_EN:
  - Defined: each iIrq bit passes through a 2-flop synchronizer before edge detection (asynchronous sources allowed).
  - Undefined: iIrq is assumed synchronous to clk and edge-detected directly, giving 2 cycles less latency.

## Structure
- Package pc_unit_pkg:
  - PCSrc encodings PCSRC_PLUS4/BRANCH/JUMP/REG.
  - Default vector constants.
  - A function for the id width.
- Sub-module irq_pending: optional synchronizer, edge detect, pending register, mask AND, priority encoder. Outputs: any-eligible and winner id. Input: clear strobe plus id.

## Test plan
- Reset:
  - Release reset: oPC=8000_0000, oKernel=1.
  - jr with iRegTarget=0000_0040: oPC=0000_0040, oKernel=0.
- Branch and jump:
  - At PC=0000_0040, branch taken, offset=-1: oPC=0000_0040.
  - Jump index=0x10 from user mode: oPC=0000_0040, kernel bit stays 0.
- IRQ priority:
  - Pulse iIrq=4'b0110, mask=4'b1111, user mode, PC=0000_0100.
  - Expected: oIrqTaken with oIrqId=1, oSquash=1, EPC=0000_0100, oPC=8000_0004.
  - ERET then returns to 0000_0100; line 2 is taken next.
- Overflow plus stall:
  - iOverflow with iStall=1: no exception, PC held.
  - Deassert iStall with iOverflow still high: oExcTaken=1, oPC=8000_0008, EPC=faulting PC.
- Masking and kernel mode:
  - IRQ edge while in kernel or masked: not taken.
  - After ERET to user with the mask enabled: taken within 1 cycle.
- Simultaneous events: overflow and an eligible IRQ in the same cycle: exception wins, pending bit is retained.
